logic_unit_arbiter: RTL
=======================

# logic_unit_arbiter

Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters in the ALU datapath. It uses round-robin arbitration, captures the granted operands into a register, and returns a registered result to the winning requester over a valid/ready response channel. At most one operation is outstanding at a time.

## Interface
- WIDTH, default 32: operand and result width.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 presents an operation.
- req0_ready  output  1  arbiter accepts requester 0 this cycle.
- req0_op  input  2  requester 0 opcode.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- rsp0_valid  output  1  result for requester 0 is valid.
- rsp0_ready  input  1  requester 0 consumes the result.
- rsp0_data  output  WIDTH  result for requester 0.
- req1_* and rsp1_*: identical set for requester 1.
- rsp0_zero, rsp1_zero  output  1  result-is-zero flag; present only with LU_ARB_ZERO_FLAG_EN.

## Operation
- Opcodes: 2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 NOR, all bitwise over WIDTH bits.
- FSM states:
  - IDLE: no operation outstanding.
  - BUSY: result is held and waiting for the response handshake.
- IDLE: reqN_ready = 1 only for the granted requester; the other requester's ready = 0.
- Grant in IDLE:
  - Only one reqN_valid high: grant that requester.
  - Both high: grant the requester not in last_grant.
  - Neither high: no grant, stay IDLE.
- Accept (reqN_valid & reqN_ready):
  - Compute the result combinationally from the requester's op/a/b and register it into data_q.
  - Record owner = N and set last_grant = N.
  - Go to BUSY.
- BUSY:
  - rspN_valid = 1 only for the owner; all req*_ready = 0.
  - rspN_data = data_q, stable until the handshake.
  - On rspN_valid & rspN_ready, return to IDLE.
- rsp*_data of the non-owner, and of both requesters in IDLE, is don't-care; drive data_q.
- A request is never granted in the same cycle as a response handshake; the minimum issue interval is 2 cycles.
- Requesters must hold valid, op and operands stable until ready; the arbiter never drops an offered request.
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first contention), owner = 0.
  - data_q = 0, all rsp*_valid = 0.
- Reset asserted during BUSY: the pending result is discarded and rsp*_valid falls immediately (asynchronous).

## Timing
- Request accepted at edge T; rspN_valid is high from cycle T+1.
- Latency from request to result: 1 cycle.
- ready is a function of state, last_grant and both req*_valid only; it is never a function of rsp*_ready.
- rsp*_valid and rsp*_data come directly from flops, with no combinational path from inputs.
- Back-to-back throughput with rsp_ready held high: one operation every 2 cycles.
- Fairness: under continuous contention, grants alternate 0,1,0,1…; neither requester waits more than one operation.

## Configuration
- LU_ARB_ZERO_FLAG_EN defined:
  - Adds the rsp0_zero/rsp1_zero ports.
  - A zero_q flop is loaded with (result == 0) at accept and reset to 0.
  - The flag is valid when the matching rsp*_valid is high.
- Not defined: the ports and the flop are absent, and behaviour is otherwise identical.

## Structure
- Shared package lu_pkg:
  - Opcode constants LU_AND=2'b00, LU_OR=2'b01, LU_XOR=2'b10, LU_NOR=2'b11.
  - State encodings ST_IDLE/ST_BUSY.
- One sub-module, logic_unit:
  - Purely combinational, ports (out, a, b, op), WIDTH-parameterised.
  - Instantiated once after the grant mux.

## Test plan
- Reset: assert reset mid-BUSY → both rsp_valid = 0 immediately; after release, state IDLE and data_q = 0.
- Single op: req0 AND a=32'hFFFF_0000, b=32'h0F0F_0F0F at T → rsp0_valid at T+1 with data 32'h0F0F_0000; rsp1_valid stays 0.
- All opcodes: a=32'hAAAA_AAAA, b=32'h0000_FFFF:
  - OR → 32'hAAAA_FFFF
  - XOR → 32'hAAAA_5555
  - NOR → 32'h5555_0000
- Contention: both valid continuously, rsp_ready = 1 → grants 0,1,0,1, one result every 2 cycles, and each result is routed to the correct owner.
- Backpressure: rsp1_ready held 0 for 5 cycles → rsp1_valid and rsp1_data stable, req0_ready = 0 throughout; req0 is granted in the cycle after rsp1_ready rises.
- With LU_ARB_ZERO_FLAG_EN: AND a=32'hF0F0_F0F0, b=32'h0F0F_0F0F → data 0, rsp0_zero = 1; OR of the same operands → rsp0_zero = 0.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit arbiter: opcodes and FSM state encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lu_pkg;

    localparam logic [1:0] LU_AND = 2'b00;
    localparam logic [1:0] LU_OR  = 2'b01;
    localparam logic [1:0] LU_XOR = 2'b10;
    localparam logic [1:0] LU_NOR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,  // no operation outstanding
        ST_BUSY = 1'b1   // result held, waiting for the response handshake
    } lu_state_e;

endpackage

// File: rtl/logic_unit.sv
// Bitwise logic unit: AND/OR/XOR/NOR of a and b selected by op.
// Latency: purely combinational, 0 cycles.
// Backpressure: none, no handshake.
// Ports: out (result), a/b (WIDTH-bit operands), op (2-bit opcode from lu_pkg).
module logic_unit
    import lu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op
);

    always_comb begin
        out = a & b;
        case (op)
            LU_AND:  out = a & b;
            LU_OR:   out = a | b;
            LU_XOR:  out = a ^ b;
            LU_NOR:  out = ~(a | b);
            default: out = a & b;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between two requesters, one op outstanding.
// Latency: request accepted at edge T, registered result valid from cycle T+1.
// Backpressure: while a result waits for rspN_ready, both req*_ready stay low.
// Ports: clk, reset (async active-high); per requester N: reqN_valid/ready/op/a/b,
//        rspN_valid/ready/data. Optional macro LU_ARB_ZERO_FLAG_EN adds rsp0_zero/rsp1_zero.
module logic_unit_arbiter
    import lu_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef LU_ARB_ZERO_FLAG_EN
    output logic             rsp0_zero,
    output logic             rsp1_zero,
`endif
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data
);

    lu_state_e        state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] data_q, data_d;
    // Per-requester valid flops so rsp*_valid leave the block straight from a register.
    logic [1:0]       rsp_vld_q, rsp_vld_d;

    logic             grant0;
    logic             grant1;
    logic             rsp_hs;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] lu_out;

    // Grant depends only on state, last_grant and the two valids. On contention
    // the requester that did not win last time is chosen.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid && (!req1_valid || last_grant_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .out (lu_out),
        .a   (sel_a),
        .b   (sel_b),
        .op  (sel_op)
    );

    assign rsp_hs = owner_q ? (rsp_vld_q[1] && rsp1_ready) : (rsp_vld_q[0] && rsp0_ready);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        data_d       = data_q;
        rsp_vld_d    = rsp_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    state_d      = ST_BUSY;
                    data_d       = lu_out;
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    rsp_vld_d    = {grant1, grant0};
                end
            end
            ST_BUSY: begin
                // Returning to IDLE here means a new grant can only happen on the
                // following cycle, giving the 2-cycle issue interval.
                if (rsp_hs) begin
                    state_d   = ST_IDLE;
                    rsp_vld_d = 2'b00;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rsp_vld_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            data_q       <= '0;
            rsp_vld_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            data_q       <= data_d;
            rsp_vld_q    <= rsp_vld_d;
        end
    end

    assign rsp0_valid = rsp_vld_q[0];
    assign rsp1_valid = rsp_vld_q[1];
    assign rsp0_data  = data_q;
    assign rsp1_data  = data_q;

`ifdef LU_ARB_ZERO_FLAG_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (grant0 || grant1) begin
            zero_d = (lu_out == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign rsp0_zero = zero_q;
    assign rsp1_zero = zero_q;
`endif

endmodule
